// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream slave stage.
// Defines the buffered beat layout, the output framing states and a saturating-increment helper.
package axis_pkg;

  localparam int PKT_LEN_W = 16;
  localparam int STALL_W   = 8;

  // Field order fixes the 43-bit FIFO entry layout {data, strb, keep, user, last}.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic [1:0]  user;
    logic        last;
  } axis_beat_t;

  typedef enum logic {
    O_IDLE = 1'b0,
    O_PKT  = 1'b1
  } out_state_t;

  function automatic logic [PKT_LEN_W-1:0] sat_inc_len(input logic [PKT_LEN_W-1:0] v);
    return (v == {PKT_LEN_W{1'b1}}) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axis_sfifo.sv
// Synchronous first-word-fall-through FIFO with synchronous flush.
// The head entry is presented whenever the FIFO holds data; the output is zero when it is empty.
module axis_sfifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  // Full/empty come only from the registered count, so ready never depends on rd_rdy.
  assign wr_rdy  = (count_r != FULL_C);
  assign rd_vld  = (count_r != {CW{1'b0}});
  assign wr_en_s = wr_vld & wr_rdy & ~clear;
  assign rd_en_s = rd_vld & rd_rdy & ~clear;
  assign rd_data = rd_vld ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};

  // Pointer and occupancy tracking; flush wins over any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are only observable through rd_vld-gated rd_data.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/axis_slave.sv
// AXI-Stream slave: buffers beats in a FWFT FIFO and hands them to the backend with
// packet framing, per-packet beat count and a backend-stall indicator.
module axis_slave
  import axis_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 axis_tvalid,
  input  logic [31:0]          axis_tdata,
  input  logic [3:0]           axis_tstrb,
  input  logic [3:0]           axis_tkeep,
  input  logic [1:0]           axis_tuser,
  input  logic                 axis_tlast,
  output logic                 axis_tready,
  output logic                 bk_valid,
  output logic [31:0]          bk_data,
  output logic [3:0]           bk_tstrb,
  output logic [3:0]           bk_tkeep,
  output logic [1:0]           bk_user,
  output logic                 bk_last,
  output logic                 bk_first,
  input  logic                 bk_ready,
  output logic                 bk_pkt_done,
  output logic [PKT_LEN_W-1:0] bk_pkt_len,
  output logic                 bk_nordy
);

  localparam logic [STALL_W-1:0] TIMEOUT_C = STALL_W'(TIMEOUT);

  axis_beat_t           wr_beat_s;
  axis_beat_t           head_s;
  logic                 store_s;
  logic                 deliver_s;
  out_state_t           state_r;
  out_state_t           state_nxt_s;
  logic [PKT_LEN_W-1:0] beat_cnt_r;
  logic [PKT_LEN_W-1:0] pkt_len_r;
  logic                 pkt_done_r;
  logic [STALL_W-1:0]   stall_cnt_r;

  assign wr_beat_s = '{data: axis_tdata, strb: axis_tstrb, keep: axis_tkeep,
                       user: axis_tuser, last: axis_tlast};
  // Null beats are swallowed unless they carry tlast, so a packet end is never lost.
  assign store_s   = axis_tvalid & ((axis_tkeep != 4'h0) | axis_tlast);

  axis_sfifo #(
    .WIDTH ($bits(axis_beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .wr_vld  (store_s),
    .wr_rdy  (axis_tready),
    .wr_data (wr_beat_s),
    .rd_vld  (bk_valid),
    .rd_rdy  (bk_ready),
    .rd_data (head_s)
  );

  assign deliver_s   = bk_valid & bk_ready;
  assign bk_data     = head_s.data;
  assign bk_tstrb    = head_s.strb;
  assign bk_tkeep    = head_s.keep;
  assign bk_user     = head_s.user;
  assign bk_last     = head_s.last;
  assign bk_first    = bk_valid & (state_r == O_IDLE);
  assign bk_pkt_done = pkt_done_r;
  assign bk_pkt_len  = pkt_len_r;
  assign bk_nordy    = (stall_cnt_r >= TIMEOUT_C);

  // Framing next-state: a delivered non-last beat opens a packet, a delivered last beat closes it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      O_IDLE: begin
        if (deliver_s && !head_s.last) state_nxt_s = O_PKT;
        else                           state_nxt_s = O_IDLE;
      end
      O_PKT: begin
        if (deliver_s && head_s.last) state_nxt_s = O_IDLE;
        else                          state_nxt_s = O_PKT;
      end
      default: state_nxt_s = O_IDLE;
    endcase
  end

  // Framing state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state_r <= O_IDLE;
    else if (clear) state_r <= O_IDLE;
    else            state_r <= state_nxt_s;
  end

  // Beat counter, delivered-packet length and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= {PKT_LEN_W{1'b0}};
      pkt_len_r  <= {PKT_LEN_W{1'b0}};
      pkt_done_r <= 1'b0;
    end else if (clear) begin
      beat_cnt_r <= {PKT_LEN_W{1'b0}};
      pkt_len_r  <= {PKT_LEN_W{1'b0}};
      pkt_done_r <= 1'b0;
    end else begin
      pkt_done_r <= deliver_s & head_s.last;
      if (deliver_s && head_s.last) begin
        beat_cnt_r <= {PKT_LEN_W{1'b0}};
        pkt_len_r  <= sat_inc_len(beat_cnt_r);
      end else if (deliver_s) begin
        beat_cnt_r <= sat_inc_len(beat_cnt_r);
      end
    end
  end

  // Consecutive-stall counter: counts cycles the head beat waits on the backend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {STALL_W{1'b0}};
    end else if (clear) begin
      stall_cnt_r <= {STALL_W{1'b0}};
    end else if (bk_valid && !bk_ready) begin
      if (stall_cnt_r != {STALL_W{1'b1}}) stall_cnt_r <= stall_cnt_r + 8'd1;
    end else begin
      stall_cnt_r <= {STALL_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_axis_slave.sv
// Testbench for axis_slave: scoreboard plus cycle model checked every cycle, a packet vector
// table, and directed sequences for fill/stall, simultaneous transfer, clear and reset.
module tb_axis_slave;
  import axis_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        axis_tvalid = 1'b0;
  logic [31:0] axis_tdata = 32'h0;
  logic [3:0]  axis_tstrb = 4'h0;
  logic [3:0]  axis_tkeep = 4'h0;
  logic [1:0]  axis_tuser = 2'h0;
  logic        axis_tlast = 1'b0;
  logic        axis_tready;
  logic        bk_valid;
  logic [31:0] bk_data;
  logic [3:0]  bk_tstrb;
  logic [3:0]  bk_tkeep;
  logic [1:0]  bk_user;
  logic        bk_last;
  logic        bk_first;
  logic        bk_ready = 1'b0;
  logic        bk_pkt_done;
  logic [15:0] bk_pkt_len;
  logic        bk_nordy;

  always #5 clk = ~clk;

  axis_slave #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .axis_tvalid(axis_tvalid), .axis_tdata(axis_tdata), .axis_tstrb(axis_tstrb),
    .axis_tkeep(axis_tkeep), .axis_tuser(axis_tuser), .axis_tlast(axis_tlast),
    .axis_tready(axis_tready),
    .bk_valid(bk_valid), .bk_data(bk_data), .bk_tstrb(bk_tstrb), .bk_tkeep(bk_tkeep),
    .bk_user(bk_user), .bk_last(bk_last), .bk_first(bk_first), .bk_ready(bk_ready),
    .bk_pkt_done(bk_pkt_done), .bk_pkt_len(bk_pkt_len), .bk_nordy(bk_nordy)
  );

  int errors = 0;
  int checks = 0;
  int n_delivered = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state, advanced once per cycle at the falling edge.
  axis_beat_t  sb_q[$];
  axis_beat_t  got_s;
  axis_beat_t  drv_s;
  axis_beat_t  head;
  logic        exp_in_pkt = 1'b0;
  logic [15:0] exp_bcnt = 16'h0;
  logic [15:0] exp_len = 16'h0;
  logic        exp_done = 1'b0;
  logic [7:0]  exp_stall = 8'h0;
  bit          was_full;
  bit          was_valid;

  assign got_s = {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_last};
  assign drv_s = {axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast};

  task automatic model_flush();
    sb_q.delete();
    exp_in_pkt = 1'b0;
    exp_bcnt   = 16'h0;
    exp_len    = 16'h0;
    exp_done   = 1'b0;
    exp_stall  = 8'h0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_flush();
    end else begin
      was_full  = (sb_q.size() == DEPTH);
      was_valid = (sb_q.size() != 0);
      chk("tready",   64'(axis_tready), 64'(!was_full));
      chk("bk_valid", 64'(bk_valid),    64'(was_valid));
      chk("bk_first", 64'(bk_first),    64'(was_valid && !exp_in_pkt));
      chk("pkt_done", 64'(bk_pkt_done), 64'(exp_done));
      chk("pkt_len",  64'(bk_pkt_len),  64'(exp_len));
      chk("nordy",    64'(bk_nordy),    64'(exp_stall >= 8'(TIMEOUT)));
      if (!was_valid) chk("empty_fields", 64'(got_s), 64'h0);
      exp_done = 1'b0;
      if (clear) begin
        model_flush();
      end else begin
        if (was_valid && !bk_ready) exp_stall = (exp_stall == 8'hFF) ? exp_stall : exp_stall + 8'd1;
        else                        exp_stall = 8'h0;
        if (was_valid && bk_ready) begin
          head = sb_q.pop_front();
          n_delivered++;
          chk("beat", 64'(got_s), 64'(head));
          if (head.last) begin
            exp_done   = 1'b1;
            exp_len    = (exp_bcnt == 16'hFFFF) ? exp_bcnt : exp_bcnt + 16'd1;
            exp_bcnt   = 16'h0;
            exp_in_pkt = 1'b0;
          end else begin
            exp_bcnt   = (exp_bcnt == 16'hFFFF) ? exp_bcnt : exp_bcnt + 16'd1;
            exp_in_pkt = 1'b1;
          end
        end
        if (axis_tvalid && !was_full && (axis_tkeep != 4'h0 || axis_tlast)) sb_q.push_back(drv_s);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until it is accepted; returns just after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit acc;
    acc = 1'b0;
    axis_tvalid = 1'b1;
    axis_tdata  = d;
    axis_tstrb  = 4'($urandom);
    axis_tkeep  = k;
    axis_tuser  = 2'($urandom);
    axis_tlast  = l;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      acc = axis_tready;
      step();
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  // Wait (bounded) for the done pulse, then check the reported length.
  task automatic wait_done(input string name, input logic [15:0] exp_l);
    bit found;
    logic [15:0] len;
    found = 1'b0;
    len = 16'h0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bk_pkt_done) begin
        found = 1'b1;
        len = bk_pkt_len;
        break;
      end
    end
    chk({name, "_done_seen"}, 64'(found), 64'd1);
    chk({name, "_len"}, 64'(len), 64'(exp_l));
    step();
  endtask

  typedef struct {
    int          nbeats;
    int          null_pos;
    bit          end_null;
    logic [15:0] exp_len;
  } pkt_vec_t;

  pkt_vec_t vec[5];
  int base_cnt;

  initial begin
    vec[0] = '{1, -1, 1'b0, 16'd1};
    vec[1] = '{4, -1, 1'b0, 16'd4};
    vec[2] = '{5,  2, 1'b0, 16'd4};
    vec[3] = '{3, -1, 1'b1, 16'd3};
    vec[4] = '{6,  0, 1'b1, 16'd5};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tready", 64'(axis_tready), 64'd1);
    chk("rst_valid",  64'(bk_valid),    64'd0);
    chk("rst_first",  64'(bk_first),    64'd0);
    chk("rst_done",   64'(bk_pkt_done), 64'd0);
    chk("rst_len",    64'(bk_pkt_len),  64'd0);
    chk("rst_nordy",  64'(bk_nordy),    64'd0);
    chk("rst_fields", 64'(got_s),       64'd0);
    step();

    // Single-beat packet: visible one cycle after acceptance.
    bk_ready = 1'b0;
    send_beat(32'hA5A5_A5A5, 4'hF, 1'b1);
    axis_tvalid = 1'b0;
    chk("single_valid", 64'(bk_valid), 64'd1);
    chk("single_first", 64'(bk_first), 64'd1);
    chk("single_last",  64'(bk_last),  64'd1);
    chk("single_data",  64'(bk_data),  64'hA5A5_A5A5);
    bk_ready = 1'b1;
    step();
    chk("single_done", 64'(bk_pkt_done), 64'd1);
    chk("single_len",  64'(bk_pkt_len),  64'd1);
    step();
    chk("single_done_off", 64'(bk_pkt_done), 64'd0);

    // Packet table with backend always ready.
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < vec[i].nbeats; b++) begin
        send_beat(32'h1000_0000 + 32'(i * 256 + b),
                  (b == vec[i].null_pos || (b == vec[i].nbeats - 1 && vec[i].end_null)) ? 4'h0 : 4'hF,
                  1'(b == vec[i].nbeats - 1));
      end
      axis_tvalid = 1'b0;
      wait_done($sformatf("vec%0d", i), vec[i].exp_len);
    end

    // Fill while stalled, hold a ninth beat against a full FIFO, then release.
    bk_ready = 1'b0;
    for (int b = 0; b < 8; b++) send_beat(32'hF000_0000 + 32'(b), 4'hF, 1'(b == 7));
    axis_tvalid = 1'b1;
    axis_tdata  = 32'hDEAD_0009;
    axis_tkeep  = 4'hF;
    axis_tlast  = 1'b1;
    step();
    chk("full_tready", 64'(axis_tready), 64'd0);
    repeat (4) step();
    chk("stall_nordy", 64'(bk_nordy), 64'd1);
    bk_ready = 1'b1;
    step();
    chk("tready_after_deliver", 64'(axis_tready), 64'd1);
    step();
    axis_tvalid = 1'b0;
    wait_done("fill8", 16'd8);
    wait_done("fill9", 16'd1);

    // Simultaneous write and deliver at three buffered beats.
    bk_ready = 1'b0;
    for (int b = 0; b < 3; b++) send_beat(32'h3300_0000 + 32'(b), 4'hF, 1'b0);
    bk_ready = 1'b1;
    send_beat(32'h3300_0003, 4'hF, 1'b1);
    axis_tvalid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("simul_cnt_valid", 64'(bk_valid), 64'd1);
      step();
    end
    @(negedge clk);
    chk("simul_cnt_empty", 64'(bk_valid), 64'd0);
    step();

    // Random traffic, many pointer wraps.
    base_cnt = n_delivered;
    for (int c = 0; c < 120; c++) begin
      axis_tvalid = ($urandom_range(0, 3) != 0);
      axis_tdata  = $urandom;
      axis_tstrb  = 4'($urandom);
      axis_tkeep  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      axis_tuser  = 2'($urandom);
      axis_tlast  = ($urandom_range(0, 3) == 0);
      bk_ready    = ($urandom_range(0, 3) != 0);
      step();
    end
    axis_tvalid = 1'b0;
    bk_ready = 1'b1;
    repeat (12) step();
    chk("wrap_enough_beats", 64'(n_delivered - base_cnt >= 20), 64'd1);
    chk("wrap_drained", 64'(bk_valid), 64'd0);

    // Establish a nonzero length, then clear mid-packet with five beats buffered.
    send_beat(32'h4400_0000, 4'hF, 1'b0);
    send_beat(32'h4400_0001, 4'hF, 1'b1);
    axis_tvalid = 1'b0;
    wait_done("pre_clear", 16'd2);
    bk_ready = 1'b0;
    for (int b = 0; b < 6; b++) send_beat(32'h5500_0000 + 32'(b), 4'hF, 1'b0);
    axis_tvalid = 1'b0;
    bk_ready = 1'b1;
    step();
    bk_ready = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_valid",  64'(bk_valid),    64'd0);
    chk("clear_tready", 64'(axis_tready), 64'd1);
    chk("clear_len",    64'(bk_pkt_len),  64'd0);
    chk("clear_nordy",  64'(bk_nordy),    64'd0);
    send_beat(32'h6600_0000, 4'hF, 1'b1);
    axis_tvalid = 1'b0;
    chk("clear_next_first", 64'(bk_first), 64'd1);
    bk_ready = 1'b1;
    wait_done("post_clear", 16'd1);

    // Asynchronous reset mid-packet.
    bk_ready = 1'b0;
    for (int b = 0; b < 3; b++) send_beat(32'h7700_0000 + 32'(b), 4'hF, 1'b0);
    axis_tvalid = 1'b0;
    bk_ready = 1'b1;
    step();
    bk_ready = 1'b0;
    #2 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("reset_valid", 64'(bk_valid), 64'd0);
    send_beat(32'h8800_0000, 4'hF, 1'b1);
    axis_tvalid = 1'b0;
    chk("reset_next_first", 64'(bk_first), 64'd1);
    bk_ready = 1'b1;
    wait_done("post_reset", 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
